// File: rtl/stripe_pkg.sv
// Shared definitions for the byte-striping scheduler: alignment marker,
// scheduler state encoding and lane-index helpers.
package stripe_pkg;

    // Alignment marker sent on every enabled lane when alignment is built in
    localparam logic [7:0] K_ALIGN = 8'hBC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ALIGN = 2'd2
    } state_t;

    // Width of a lane index; a single lane still needs one bit
    function automatic int lane_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    // Lowest set bit of a (zero-extended) lane mask, 0 when the mask is empty
    function automatic logic [2:0] lowest_set(input logic [7:0] mask);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/stripe_lane_scheduler_rr_next_lane.sv
// Round-robin lane picker: given the active lane mask and the current lane,
// reports the next enabled lane above it, whether the round wraps, and the
// lowest enabled lane.
module rr_next_lane #(
    parameter int LANES = 2,
    parameter int IW    = 1
) (
    input  logic [LANES-1:0] mask,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    next_idx,
    output logic             wrap,
    output logic [IW-1:0]    low_idx
);

    // Scan downwards so the last hit is the lowest qualifying lane
    always_comb begin
        low_idx  = '0;
        next_idx = '0;
        wrap     = 1'b1;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx = IW'(i);
            end
            if (mask[i] && (i > int'(ptr))) begin
                next_idx = IW'(i);
                wrap     = 1'b0;
            end
        end
        if (wrap) begin
            next_idx = low_idx;
        end
    end

endmodule

// File: rtl/stripe_lane_scheduler.sv
// Byte-striping scheduler: deals one source byte per cycle round-robin over
// the enabled lanes, stalls the source on lane backpressure and only picks up
// lane-enable changes at round boundaries.
// Optional feature: define STRIPE_ALIGN_EN to insert an alignment marker on all
// enabled lanes after every ALIGN_PERIOD complete rounds.
module stripe_lane_scheduler
    import stripe_pkg::*;
#(
    parameter int LANES        = 2,
    parameter int DW           = 8,
    parameter int ALIGN_PERIOD = 16
) (
    input  logic                clk_2f,
    input  logic                reset,
    input  logic [DW-1:0]       data_in,
    input  logic                valid_in,
    output logic                ready_out,
    input  logic [LANES-1:0]    lane_en,
    input  logic [LANES-1:0]    lane_ready,
    output logic [LANES*DW-1:0] lane_data,
    output logic [LANES-1:0]    lane_valid
);

    localparam int IW = lane_idx_w(LANES);

`ifdef STRIPE_ALIGN_EN
    localparam int             RC_W   = (ALIGN_PERIOD > 1) ? $clog2(ALIGN_PERIOD) : 1;
    localparam logic [RC_W-1:0] RC_MAX = RC_W'(ALIGN_PERIOD - 1);

    logic [RC_W-1:0] round_cnt;
    logic [RC_W-1:0] round_cnt_n;
`endif

    state_t             state;
    state_t             state_n;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      ptr_n;
    logic [IW-1:0]      next_idx;
    logic [IW-1:0]      low_idx;
    logic [IW-1:0]      reload_idx;
    logic               wrap;
    logic               transfer;
    logic [LANES-1:0]   en_shadow;
    logic [LANES-1:0]   en_shadow_n;
    logic [LANES-1:0]   lane_valid_n;
    logic [LANES*DW-1:0] lane_data_n;

    rr_next_lane #(
        .LANES (LANES),
        .IW    (IW)
    ) u_rr_next_lane (
        .mask     (en_shadow),
        .ptr      (ptr),
        .next_idx (next_idx),
        .wrap     (wrap),
        .low_idx  (low_idx)
    );

    assign ready_out  = (state == RUN) && lane_ready[ptr];
    assign transfer   = valid_in && ready_out;
    assign reload_idx = IW'(lowest_set(8'(lane_en)));

    // Next-state, lane pointer, shadow mask and lane output computation
    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        en_shadow_n  = en_shadow;
        lane_data_n  = lane_data;
        lane_valid_n = '0;
`ifdef STRIPE_ALIGN_EN
        round_cnt_n  = round_cnt;
`endif
        case (state)
            IDLE: begin
                en_shadow_n = lane_en;
                ptr_n       = reload_idx;
                if (lane_en != '0) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (transfer) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (ptr == IW'(i)) begin
                            lane_data_n[i*DW +: DW] = data_in;
                            lane_valid_n[i]         = 1'b1;
                        end
                    end
                    if (!wrap) begin
                        ptr_n = next_idx;
                    end else begin
                        en_shadow_n = lane_en;
                        ptr_n       = reload_idx;
`ifdef STRIPE_ALIGN_EN
                        if (round_cnt != RC_MAX) begin
                            round_cnt_n = round_cnt + 1'b1;
                        end
`endif
                        if (lane_en == '0) begin
                            state_n = IDLE;
                        end
`ifdef STRIPE_ALIGN_EN
                        else if (round_cnt == RC_MAX) begin
                            state_n = ALIGN;
                        end
`endif
                    end
                end
            end
`ifdef STRIPE_ALIGN_EN
            ALIGN: begin
                if ((en_shadow & ~lane_ready) == '0) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (en_shadow[i]) begin
                            lane_data_n[i*DW +: DW] = DW'(K_ALIGN);
                            lane_valid_n[i]         = 1'b1;
                        end
                    end
                    round_cnt_n = '0;
                    ptr_n       = low_idx;
                    state_n     = RUN;
                end
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, pointer, shadow mask and registered lane outputs
    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            en_shadow  <= '0;
            lane_data  <= '0;
            lane_valid <= '0;
`ifdef STRIPE_ALIGN_EN
            round_cnt  <= '0;
`endif
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            en_shadow  <= en_shadow_n;
            lane_data  <= lane_data_n;
            lane_valid <= lane_valid_n;
`ifdef STRIPE_ALIGN_EN
            round_cnt  <= round_cnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_stripe_lane_scheduler.sv
// Testbench for stripe_lane_scheduler: directed scenarios followed by random
// traffic, scored against a lane-list reference model with per-lane queues.
module tb_stripe_lane_scheduler;

    localparam int LANES = 2;
    localparam int DW    = 8;
    localparam int AP    = 4;

`ifdef STRIPE_ALIGN_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] d;
        int            cyc;
    } exp_t;

    logic                clk_2f = 1'b0;
    logic                reset;
    logic [DW-1:0]       data_in;
    logic                valid_in;
    logic                ready_out;
    logic [LANES-1:0]    lane_en;
    logic [LANES-1:0]    lane_ready;
    logic [LANES*DW-1:0] lane_data;
    logic [LANES-1:0]    lane_valid;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            cyc = 0;
    bit            mon_en = 1'b0;
    int            m_mode = 0;
    int            m_pos = 0;
    int            m_rounds = 0;
    bit            m_accepted = 1'b0;
    int            lst[$];
    logic [DW-1:0] m_data[LANES];
    exp_t          lq[LANES][$];

    stripe_lane_scheduler #(
        .LANES        (LANES),
        .DW           (DW),
        .ALIGN_PERIOD (AP)
    ) dut (
        .clk_2f     (clk_2f),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .lane_en    (lane_en),
        .lane_ready (lane_ready),
        .lane_data  (lane_data),
        .lane_valid (lane_valid)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic loadList(input logic [LANES-1:0] en);
        lst.delete();
        for (int i = 0; i < LANES; i++) begin
            if (en[i]) lst.push_back(i);
        end
    endtask

    task automatic pushExp(input int ln, input logic [DW-1:0] d);
        exp_t e;
        e.d   = d;
        e.cyc = cyc;
        lq[ln].push_back(e);
        m_data[ln] = d;
    endtask

    // Model: the enabled lanes form a list snapshotted at each round boundary;
    // bytes go to list positions in order and the list is re-read after the last.
    task automatic modelStep();
        bit all_rdy;
        cyc++;
        m_accepted = 1'b0;
        if (!reset) begin
            m_mode   = 0;
            m_pos    = 0;
            m_rounds = 0;
            lst.delete();
            for (int i = 0; i < LANES; i++) m_data[i] = '0;
            mon_en = 1'b1;
        end else begin
            case (m_mode)
                0: begin
                    loadList(lane_en);
                    m_pos = 0;
                    if (lst.size() > 0) m_mode = 1;
                end
                1: begin
                    if (valid_in && lane_ready[lst[m_pos]]) begin
                        m_accepted = 1'b1;
                        pushExp(lst[m_pos], data_in);
                        m_pos++;
                        if (m_pos == lst.size()) begin
                            m_rounds++;
                            loadList(lane_en);
                            m_pos = 0;
                            if (lst.size() == 0) m_mode = 0;
                            else if (ALIGN_ON && m_rounds >= AP) m_mode = 2;
                        end
                    end
                end
                default: begin
                    all_rdy = 1'b1;
                    foreach (lst[k]) if (!lane_ready[lst[k]]) all_rdy = 1'b0;
                    if (all_rdy) begin
                        foreach (lst[k]) pushExp(lst[k], 8'hBC);
                        m_rounds = 0;
                        m_pos    = 0;
                        m_mode   = 1;
                    end
                end
            endcase
        end
    endtask

    // Monitor: compares handshake, held lane data and every lane pulse
    task automatic monitorStep();
        logic [LANES*DW-1:0] ev;
        bit                  exp_ready;
        exp_t                e;
        exp_ready = (m_mode == 1) && lane_ready[lst[m_pos]];
        checkOutput("ready_out", 64'(ready_out), 64'(exp_ready));
        for (int i = 0; i < LANES; i++) ev[i*DW +: DW] = m_data[i];
        checkOutput("lane_data_held", 64'(lane_data), 64'(ev));
        for (int i = 0; i < LANES; i++) begin
            if (lane_valid[i]) begin
                if (lq[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pulse lane %0d cycle %0d: got data %0h expected no pulse",
                             i, cyc, lane_data[i*DW +: DW]);
                end else begin
                    e = lq[i].pop_front();
                    checkOutput($sformatf("lane%0d_data", i), 64'(lane_data[i*DW +: DW]), 64'(e.d));
                    checkOutput($sformatf("lane%0d_cycle", i), 64'(cyc), 64'(e.cyc));
                end
            end else if (lq[i].size() > 0 && lq[i][0].cyc <= cyc) begin
                e = lq[i].pop_front();
                checks++;
                errors++;
                $display("[TB] FAIL missing_pulse lane %0d cycle %0d: got no pulse expected data %0h",
                         i, cyc, e.d);
            end
        end
    endtask

    initial forever begin
        @(posedge clk_2f);
        modelStep();
    end

    initial forever begin
        @(negedge clk_2f);
        if (mon_en) monitorStep();
    end

    task automatic applyStimulus(input logic r, input logic v, input logic [DW-1:0] d,
                                 input logic [LANES-1:0] en, input logic [LANES-1:0] rdy);
        reset      = r;
        valid_in   = v;
        data_in    = d;
        lane_en    = en;
        lane_ready = rdy;
        @(posedge clk_2f);
        #1;
    endtask

    // Hold one byte on the source until the model says it was taken
    task automatic sendByte(input logic [DW-1:0] d, input logic [LANES-1:0] en,
                            input logic [LANES-1:0] rdy);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 1'b1, d, en, rdy);
            if (m_accepted) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL send_timeout byte %0h: got no acceptance expected within 20 cycles", d);
    endtask

    initial begin
        logic           cur_v;
        logic [DW-1:0]  cur_d;
        logic [LANES-1:0] cur_en;

        reset      = 1'b0;
        valid_in   = 1'b0;
        data_in    = '0;
        lane_en    = '0;
        lane_ready = '0;

        $display("[TB] reset with random inputs");
        for (int i = 0; i < 2; i++)
            applyStimulus(1'b0, 1'($urandom), DW'($urandom), LANES'($urandom), LANES'($urandom));

        $display("[TB] back-to-back striping over two lanes");
        applyStimulus(1'b1, 1'b0, '0, 2'b11, 2'b11);
        for (int b = 1; b <= 4; b++) sendByte(DW'(b), 2'b11, 2'b11);

        $display("[TB] stall on lane1 backpressure");
        sendByte(8'h01, 2'b11, 2'b11);
        applyStimulus(1'b1, 1'b1, 8'h02, 2'b11, 2'b01);
        applyStimulus(1'b1, 1'b1, 8'h02, 2'b11, 2'b01);
        sendByte(8'h02, 2'b11, 2'b11);
        sendByte(8'h03, 2'b11, 2'b11);
        sendByte(8'h04, 2'b11, 2'b11);

        $display("[TB] mid-round lane enable change");
        sendByte(8'h01, 2'b11, 2'b11);
        sendByte(8'h02, 2'b01, 2'b11);
        sendByte(8'h03, 2'b01, 2'b11);
        sendByte(8'h04, 2'b01, 2'b11);
        sendByte(8'h05, 2'b11, 2'b11);

        $display("[TB] reset mid-round and disable all lanes");
        sendByte(8'h01, 2'b11, 2'b11);
        applyStimulus(1'b0, 1'b0, '0, 2'b11, 2'b11);
        sendByte(8'h02, 2'b11, 2'b11);
        sendByte(8'h03, 2'b00, 2'b11);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 8'h04, 2'b00, 2'b11);

        $display("[TB] random traffic");
        cur_v  = 1'b0;
        cur_d  = '0;
        cur_en = 2'b11;
        for (int c = 0; c < 3000; c++) begin
            if (!(cur_v && !m_accepted)) begin
                cur_v = ($urandom_range(0, 3) != 0);
                cur_d = DW'($urandom);
            end
            if ($urandom_range(0, 40) == 0) cur_en = LANES'($urandom);
            applyStimulus(($urandom_range(0, 250) != 0), cur_v, cur_d, cur_en,
                          ($urandom_range(0, 3) == 0) ? LANES'($urandom) : 2'b11);
        end

        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, '0, 2'b11, 2'b11);
        for (int i = 0; i < LANES; i++)
            checkOutput($sformatf("drain_lane%0d", i), 64'(lq[i].size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
